// File: rtl/hs_fifo_slice_if.sv
// Valid/ready link carried through the hs_fifo_slice elastic buffer.
// The upstream (tx) side uses the s_* signals and the downstream (rx) side uses the m_* signals.
// The slice takes the slave view. The surrounding logic (or a bench) takes the master view.
interface hs_fifo_slice_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_data,
        output m_valid
    );

    modport master (
        output s_data,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/hs_fifo_slice.sv
// hs_fifo_slice: elastic valid/ready buffer between the tx producer and the rx consumer.
// s_ready is registered, so rx back-pressure never reaches tx combinationally.
// m_data is registered first-word-fall-through data: the head word is presented with m_valid one edge after it is pushed.
// An 8-bit stall watchdog raises a sticky overflow_err when tx has been blocked for more than 255 consecutive cycles.
module hs_fifo_slice #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    hs_fifo_slice_if.slave   bus,
    output logic [CNT_W-1:0] count,
    output logic             overflow_err
);

    localparam int               AW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [7:0]       WD_MAX = 8'hFF;

    // Storage and pointers
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     w_rd_ptr_nxt;

    // Occupancy and registered handshake outputs
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_s_ready;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] w_m_data_nxt;

    // Transfer qualifiers
    logic              w_push;
    logic              w_pop;

    // Stall watchdog
    logic              w_stall;
    logic [7:0]        r_stall_cnt;
    logic              r_overflow;

    // Transfers use only registered flags on the slice side, so no path exists from m_ready to s_ready.
    assign w_push  = bus.s_valid && r_s_ready;
    assign w_pop   = r_m_valid && bus.m_ready;
    assign w_stall = bus.s_valid && !r_s_ready;

    // Read pointer after this edge. It is used to prefetch the next head word.
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    // Next occupancy: push-only adds one, pop-only removes one, and both or neither leave it unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path through the block can infer a latch.
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Next head word. It changes only when the head is consumed or when a word lands in an empty slice.
    always_comb begin
        w_m_data_nxt = r_m_data;
        if (w_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop))) begin
            // The word being pushed becomes the head. The old head, if any, leaves on this same edge.
            w_m_data_nxt = bus.s_data;
        end else if (w_pop && (w_count_nxt != '0)) begin
            // The entry behind the popped head was written on an earlier edge, so it is valid to read.
            w_m_data_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Storage write on push. The contents after reset are don't-care.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately left out of reset. Reset clears only the pointers and count, and those alone define which entries are live.
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.s_data;
        end
    end

    // Pointers, occupancy and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt != FULL);
            r_m_valid <= (w_count_nxt != '0);
            r_m_data  <= w_m_data_nxt;
        end
    end

    // Stall watchdog: count consecutive blocked cycles, saturate at 255, and set the sticky flag on the next blocked cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != WD_MAX) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_stall && (r_stall_cnt == WD_MAX)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign count         = r_count;
    assign overflow_err  = r_overflow;

    // Structural invariants between the occupancy and the registered flags
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= FULL);
    a_ready_flag:  assert property (@(posedge clk) disable iff (!rst_n) r_s_ready == (r_count != FULL));
    a_valid_flag:  assert property (@(posedge clk) disable iff (!rst_n) r_m_valid == (r_count != '0));

endmodule
